packet_framer: RTL
==================

// Module: packet_framer
// PURPOSE
// - Upstream stage of data_packer. Cuts an unframed byte stream into packets of confi[7:0] beats and asserts tlast on each final beat.
// - Latches confi per packet and drives it as m_confi, held stable for the whole packet, because data_packer samples confi every cycle.
// - AXI-Stream on both sides, full throughput, one register stage (skid buffer) on the output.
// PARAMETERS
// - DATA_WIDTH  8  width of s/m tdata
// - GAP_CYCLES  1  idle cycles forced between packets so the downstream counters re-arm (0..15)
// PORTS
// - clk            in   1   single clock, rising edge
// - reset          in   1   asynchronous, active-low (0 = reset)
// - confi          in   16  [7:0] packet_length, [15:8] k; sampled only in IDLE
// - flush          in   1   level; next accepted beat is forced to be last
// - s_axis_tdata   in   DATA_WIDTH  input data
// - s_axis_tvalid  in   1   input valid
// - s_axis_tready  out  1   input ready
// - m_axis_tdata   out  DATA_WIDTH  output data
// - m_axis_tvalid  out  1   output valid
// - m_axis_tready  in   1   output ready
// - m_axis_tlast   out  1   last beat of packet
// - m_confi        out  16  config of the packet in flight (feeds data_packer.confi)
// - pkt_count      out  16  packets completed; wraps at 0xFFFF
// - cfg_err        out  1   sticky; set on an illegal confi; cleared only by reset
// BEHAVIOUR
// - Reset (reset=0, async): all outputs 0; FSM=IDLE; beat count=0; skid buffer empty.
// - Legal confi: packet_length>=2 and k<packet_length. Anything else is illegal.
// - FSM states: IDLE, FRAME, GAP, ERR.
//   - IDLE, legal confi: latch confi into m_confi, set beat=1, go to FRAME in the same cycle. IDLE accepts no data (s_axis_tready=0).
//   - IDLE, illegal confi: go to ERR and set cfg_err.
//   - ERR: s_axis_tready=0. Return to IDLE on the first cycle confi is legal.
//   - FRAME: s_axis_tready = skid-buffer ready.
//     - Each accepted beat (tvalid&tready) is pushed with last=(beat==packet_length)|flush, then beat increments.
//     - On the pushed last beat go to GAP, with the gap counter set to GAP_CYCLES.
//   - GAP: s_axis_tready=0. Count down and enter IDLE when the count reaches 0 AND the skid buffer is empty (last beat handshaked out).
//   - GAP_CYCLES=0: go straight to the empty-wait.
// - m_confi changes only in IDLE. It is constant from the first output beat until after the tlast handshake.
// - pkt_count increments on the output handshake of a tlast beat, not on input.
// - Latency and throughput: 1 cycle s->m when the buffer is empty. Sustains 1 beat/cycle under continuous tready.
//   - Skid buffer depth is 2, so s_axis_tready is registered; no combinational path from m_axis_tready.
// - AXIS rules:
//   - m_axis_tvalid never drops without a handshake.
//   - tdata and tlast are stable while valid&!ready.
//   - Output beat order equals input order.
// - Boundary cases:
//   - flush on the final counted beat: a single tlast; flush has no further effect.
//   - flush in IDLE, GAP or ERR: ignored.
//   - confi changing mid-packet: ignored until the next IDLE.
//   - m_axis_tready low for N cycles: at most 2 beats buffered, then s_axis_tready=0. No loss, no duplication.
//   - beat counter is 8 bits and never exceeds packet_length (reset to 1 per packet).
//   - reset asserted mid-packet: partial packet discarded; tvalid=0 immediately (async). The next packet starts clean after reset release.
// STRUCTURE
// - Shared package (packer_pkg, shared with data_packer):
//   - confi_t packed struct {logic [7:0] k; logic [7:0] packet_length;}
//   - fsm enum framer_state_t {IDLE, FRAME, GAP, ERR}
//   - function confi_legal(confi_t)
// - Sub-module axis_skid_buffer #(WIDTH=DATA_WIDTH+1): 2-entry, registered ready, carries {tlast,tdata}. Reusable by data_packer's output.
// - Top level: FSM, beat/gap counters, m_confi and pkt_count registers.
// TESTING
// 1. confi=0x0304, 12 bytes 0x01..0x0C, tready=1 -> 3 packets of 4; tlast on 0x04, 0x08, 0x0C; pkt_count=3; m_confi=0x0304 throughout.
// 2. confi=0x0205, tready toggled 1010..., tvalid random -> bytes in order, tlast every 5th; s_axis_tready low within 2 beats of stall.
// 3. confi=0x0106, flush on 3rd accepted byte -> tlast on byte 3, pkt_count=1; next packet restarts beat count, tlast after 6.
// 4. confi=0x0505 (k=length) -> cfg_err=1, s_axis_tready=0; then confi=0x0205 -> normal framing resumes, cfg_err stays 1.
// 5. Change confi 0x0204->0x0108 mid-packet -> current packet still ends at 4 beats; next packet is 8 beats with m_confi=0x0108 only after the tlast handshake.
// 6. Assert reset on beat 2 of 4 with m_axis_tready=0 -> m_axis_tvalid=0 immediately; after release, a clean 4-beat packet; pkt_count=1.

Source files
------------

// File: rtl/packer_pkg.sv
// Types shared by packet_framer and data_packer.
// confi layout, framer FSM states and the confi legality rule.
package packer_pkg;

  typedef struct packed {
    logic [7:0] k;
    logic [7:0] packet_length;
  } confi_t;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    GAP,
    ERR
  } framer_state_t;

  function automatic logic confi_legal(confi_t c);
    return (c.packet_length >= 8'd2) && (c.k < c.packet_length);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream buffer with a registered in_ready.
// Full throughput at one entry; the second entry absorbs a stall.
module axis_skid_buffer #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             push;
  logic             pop;

  // cnt[1] is a flop, so in_ready never sees out_ready combinationally
  assign in_ready  = ~cnt[1];
  assign out_valid = |cnt;
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/packet_framer.sv
// Cuts a byte stream into confi-sized packets with tlast,
// holding the packet's confi on m_confi for data_packer.
module packet_framer
  import packer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           confi,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [15:0]           m_confi,
  output logic [15:0]           pkt_count,
  output logic                  cfg_err
);

  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES);

  framer_state_t state;
  framer_state_t state_d;
  confi_t        cfg_in;
  confi_t        cfg_q;
  confi_t        cfg_d;
  logic [7:0]    beat;
  logic [7:0]    beat_d;
  logic [3:0]    gap;
  logic [3:0]    gap_d;
  logic          err_d;

  logic                buf_ready;
  logic                buf_in_valid;
  logic                buf_valid;
  logic [DATA_WIDTH:0] buf_out;
  logic                acc;
  logic                last_in;
  logic                out_hs;

  assign cfg_in        = confi_t'(confi);
  assign s_axis_tready = (state == FRAME) & buf_ready;
  assign buf_in_valid  = (state == FRAME) & s_axis_tvalid;
  assign acc           = s_axis_tvalid & s_axis_tready;
  assign last_in       = (beat == cfg_q.packet_length) | flush;

  assign {m_axis_tlast, m_axis_tdata} = buf_out;
  assign m_axis_tvalid = buf_valid;
  assign m_confi       = cfg_q;
  assign out_hs        = buf_valid & m_axis_tready;

  axis_skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst_n    (reset),
    .in_data  ({last_in, s_axis_tdata}),
    .in_valid (buf_in_valid),
    .in_ready (buf_ready),
    .out_data (buf_out),
    .out_valid(buf_valid),
    .out_ready(m_axis_tready)
  );

  always_comb begin
    state_d = state;
    beat_d  = beat;
    gap_d   = gap;
    cfg_d   = cfg_q;
    err_d   = cfg_err;
    unique case (state)
      IDLE: begin
        if (confi_legal(cfg_in)) begin
          cfg_d   = cfg_in;
          beat_d  = 8'd1;
          state_d = FRAME;
        end else begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      ERR: begin
        if (confi_legal(cfg_in)) begin
          state_d = IDLE;
        end
      end
      FRAME: begin
        if (acc) begin
          if (last_in) begin
            gap_d   = GAP_INIT;
            state_d = GAP;
          end else begin
            beat_d = beat + 8'd1;
          end
        end
      end
      GAP: begin
        // wait out the gap, then for the last beat to leave
        if (gap != 4'd0) begin
          gap_d = gap - 4'd1;
        end else if (!buf_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      beat      <= 8'd0;
      gap       <= 4'd0;
      cfg_q     <= '0;
      cfg_err   <= 1'b0;
      pkt_count <= 16'd0;
    end else begin
      state   <= state_d;
      beat    <= beat_d;
      gap     <= gap_d;
      cfg_q   <= cfg_d;
      cfg_err <= err_d;
      if (out_hs && m_axis_tlast) begin
        pkt_count <= pkt_count + 16'd1;
      end
    end
  end

endmodule
